fire_expand3_scheduler: RTL and testbench

Sequencer for the shared fire2/fire3 expand-3×3 convolution datapath. It runs fire2 then fire3 on that datapath and drives the per-layer enables. It turns the datapath's per-pixel sample strobe into output-RAM write strobes and addresses, and closes the finish/ram_feedback handshake for each layer. It sits between the top-level layer sequencer (start/done) and the expand-3×3 core plus its output RAMs.

---
 rtl/fire_pkg.sv | 18 +
 rtl/pixel_wr_counter.sv | 64 ++++++
 rtl/fire_expand3_scheduler.sv | 147 ++++++++++++++
 tb/tb_fire_expand3_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_pkg.sv
// Shared definitions for the fire2/fire3 expand-3x3 datapath: scheduler states
// and the output feature-map geometry reused by the datapath timers.
package fire_pkg;

    localparam int FIRE_WOUT = 64;
    localparam int FIRE_PIX  = FIRE_WOUT ** 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN2 = 3'd1,
        ST_ACK2 = 3'd2,
        ST_GAP  = 3'd3,
        ST_RUN3 = 3'd4,
        ST_ACK3 = 3'd5,
        ST_FIN  = 3'd6
    } sched_state_e;

endpackage

// File: rtl/pixel_wr_counter.sv
// Saturating per-layer pixel counter turning datapath sample strobes into
// registered output-RAM write strobes and addresses.
module pixel_wr_counter
    import fire_pkg::*;
#(
    parameter int PIX = FIRE_PIX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    active,
    input  logic                    layer3,
    input  logic                    sample,
    output logic                    full,
    output logic                    wr_en_2,
    output logic                    wr_en_3,
    output logic [$clog2(PIX)-1:0]  wr_addr
);

    localparam int AW = $clog2(PIX);
    localparam int CW = AW + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en_2_q, wr_en_2_d;
    logic          wr_en_3_q, wr_en_3_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;

    // The datapath emits one trailing sample per layer; at the saturated count it is dropped.
    always_comb begin
        cnt_d     = cnt_q;
        wr_en_2_d = 1'b0;
        wr_en_3_d = 1'b0;
        wr_addr_d = wr_addr_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active && sample && (cnt_q < CW'(PIX))) begin
            cnt_d     = cnt_q + CW'(1);
            wr_en_2_d = ~layer3;
            wr_en_3_d = layer3;
            wr_addr_d = cnt_q[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            wr_en_2_q <= 1'b0;
            wr_en_3_q <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            wr_en_2_q <= wr_en_2_d;
            wr_en_3_q <= wr_en_3_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // Includes a sample accepted this cycle, so a finish coinciding with the last pixel is not early.
    assign full    = (cnt_d == CW'(PIX));
    assign wr_en_2 = wr_en_2_q;
    assign wr_en_3 = wr_en_3_q;
    assign wr_addr = wr_addr_q;

endmodule

// File: rtl/fire_expand3_scheduler.sv
// Runs fire2 then fire3 on the shared expand-3x3 datapath, closing each layer's
// finish/ram_feedback handshake, with a per-layer watchdog and sticky error.
module fire_expand3_scheduler
    import fire_pkg::*;
#(
    parameter int WOUT       = FIRE_WOUT,
    parameter int GAP_CYCLES = 4,
    parameter int MAX_CYCLES = 2 ** 22
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          fire2_expand_3_finish,
    input  logic                          fire3_expand_3_finish,
    input  logic                          sample,
    output logic                          fire2_expand_3_en,
    output logic                          fire3_expand_3_en,
    output logic                          ram_feedback_2,
    output logic                          ram_feedback_3,
    output logic                          wr_en_2,
    output logic                          wr_en_3,
    output logic [$clog2(WOUT**2)-1:0]    wr_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int PIX = WOUT ** 2;
    localparam int WDW = $clog2(MAX_CYCLES + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    sched_state_e   state_q, state_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           error_q, error_d;

    logic cnt_clear;
    logic cnt_active;
    logic cnt_layer3;
    logic cnt_full;

    pixel_wr_counter #(.PIX(PIX)) u_pixel_wr_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .active  (cnt_active),
        .layer3  (cnt_layer3),
        .sample  (sample),
        .full    (cnt_full),
        .wr_en_2 (wr_en_2),
        .wr_en_3 (wr_en_3),
        .wr_addr (wr_addr)
    );

    // Watchdog and gap counters default to zero, so each RUN entry starts a fresh count.
    always_comb begin
        state_d           = state_q;
        wd_d              = '0;
        gap_d             = '0;
        error_d           = error_q;
        cnt_clear         = 1'b0;
        cnt_active        = 1'b0;
        cnt_layer3        = 1'b0;
        fire2_expand_3_en = 1'b0;
        fire3_expand_3_en = 1'b0;
        ram_feedback_2    = 1'b0;
        ram_feedback_3    = 1'b0;
        done              = 1'b0;
        busy              = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = ST_RUN2;
                    cnt_clear = 1'b1;
                    error_d   = 1'b0;
                end
            end
            ST_RUN2: begin
                fire2_expand_3_en = 1'b1;
                cnt_active        = 1'b1;
                wd_d              = wd_q + WDW'(1);
                if (fire2_expand_3_finish) begin
                    if (!cnt_full) error_d = 1'b1;
                    state_d = ST_ACK2;
                end else if (wd_q == WDW'(MAX_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_ACK2: begin
                fire2_expand_3_en = 1'b1;
                ram_feedback_2    = 1'b1;
                state_d           = ST_GAP;
            end
            ST_GAP: begin
                cnt_clear = 1'b1;
                gap_d     = gap_q + GW'(1);
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = ST_RUN3;
            end
            ST_RUN3: begin
                fire3_expand_3_en = 1'b1;
                cnt_active        = 1'b1;
                cnt_layer3        = 1'b1;
                wd_d              = wd_q + WDW'(1);
                if (fire3_expand_3_finish) begin
                    if (!cnt_full) error_d = 1'b1;
                    state_d = ST_ACK3;
                end else if (wd_q == WDW'(MAX_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_ACK3: begin
                fire3_expand_3_en = 1'b1;
                ram_feedback_3    = 1'b1;
                state_d           = ST_FIN;
            end
            ST_FIN: begin
                // busy drops together with the done pulse so the sequencer sees one edge.
                done    = 1'b1;
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
            gap_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_fire_expand3_scheduler.sv
// Randomized self-checking bench for fire_expand3_scheduler with WOUT=4,
// GAP_CYCLES=4 and a 100-cycle watchdog.
module tb_fire_expand3_scheduler;

    localparam int WOUT = 4;
    localparam int PIX  = WOUT * WOUT;
    localparam int AW   = $clog2(PIX);
    localparam int GAP  = 4;
    localparam int MAXC = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          f2_fin = 1'b0;
    logic          f3_fin = 1'b0;
    logic          sample = 1'b0;
    logic          f2_en, f3_en, rf2, rf3, wr_en_2, wr_en_3, busy, done, error;
    logic [AW-1:0] wr_addr;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_err  = 1'b0;

    always #5 clk = ~clk;

    fire_expand3_scheduler #(
        .WOUT(WOUT), .GAP_CYCLES(GAP), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .fire2_expand_3_finish(f2_fin), .fire3_expand_3_finish(f3_fin),
        .sample(sample),
        .fire2_expand_3_en(f2_en), .fire3_expand_3_en(f3_en),
        .ram_feedback_2(rf2), .ram_feedback_3(rf3),
        .wr_en_2(wr_en_2), .wr_en_3(wr_en_3), .wr_addr(wr_addr),
        .busy(busy), .done(done), .error(error)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sample = 1'b0; f2_fin = 1'b0; f3_fin = 1'b0;
        step; step;
        n_checks++;
        if ({f2_en, f3_en, rf2, rf3, wr_en_2, wr_en_3, busy, done, error} !== 9'b0)
            $display("[TB] FAIL reset_outputs: got %b expected 0", {f2_en, f3_en, rf2, rf3, wr_en_2, wr_en_3, busy, done, error});
        else n_pass++;
        n_checks++;
        if (wr_addr !== '0) $display("[TB] FAIL reset_addr: got %0d expected 0", wr_addr);
        else n_pass++;
        rst = 1'b0;
        step;
    endtask

    // Model: a layer keeps a pixel count; each sample below PIX is written at that count one cycle later.
    task automatic drive_layer(input int layer, input int nsamp, input bit fin_with_last, input bit poke_start);
        int  pix;
        int  idle;
        bit  exp_wr;
        bit  fin;
        logic en_l, wr_l, wr_o, rf_l;
        pix = 0;
        for (int i = 0; i < nsamp; i++) begin
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                sample = 1'b0;
                step;
                en_l = (layer == 2) ? f2_en : f3_en;
                n_checks++;
                if (en_l !== 1'b1) $display("[TB] FAIL layer%0d_en_idle: got %b expected 1", layer, en_l);
                else n_pass++;
                n_checks++;
                if ((wr_en_2 | wr_en_3) !== 1'b0) $display("[TB] FAIL layer%0d_no_write_idle: got %b%b expected 00", layer, wr_en_2, wr_en_3);
                else n_pass++;
            end
            fin = fin_with_last && (i == nsamp - 1);
            sample = 1'b1;
            start  = poke_start && (i == nsamp / 2);
            if (layer == 2) f2_fin = fin; else f3_fin = fin;
            step;
            sample = 1'b0; start = 1'b0; f2_fin = 1'b0; f3_fin = 1'b0;
            exp_wr = (pix < PIX);
            wr_l = (layer == 2) ? wr_en_2 : wr_en_3;
            wr_o = (layer == 2) ? wr_en_3 : wr_en_2;
            en_l = (layer == 2) ? f2_en : f3_en;
            n_checks++;
            if (wr_l !== exp_wr) $display("[TB] FAIL layer%0d_wr_en sample %0d: got %b expected %b", layer, i, wr_l, exp_wr);
            else n_pass++;
            n_checks++;
            if (wr_o !== 1'b0 || en_l !== 1'b1) $display("[TB] FAIL layer%0d_exclusive sample %0d: other_wr %b en %b expected 0 1", layer, i, wr_o, en_l);
            else n_pass++;
            if (exp_wr) begin
                n_checks++;
                if (wr_addr !== pix[AW-1:0]) $display("[TB] FAIL layer%0d_wr_addr: got %0d expected %0d", layer, wr_addr, pix);
                else n_pass++;
                pix++;
            end
        end
        if (!fin_with_last) begin
            sample = 1'b0;
            step;
            if (layer == 2) f2_fin = 1'b1; else f3_fin = 1'b1;
            step;
            f2_fin = 1'b0; f3_fin = 1'b0;
            wr_l = (layer == 2) ? wr_en_2 : wr_en_3;
            n_checks++;
            if (wr_l !== 1'b0) $display("[TB] FAIL layer%0d_ack_no_write: got %b expected 0", layer, wr_l);
            else n_pass++;
        end
        rf_l = (layer == 2) ? rf2 : rf3;
        en_l = (layer == 2) ? f2_en : f3_en;
        n_checks++;
        if (rf_l !== 1'b1 || en_l !== 1'b1) $display("[TB] FAIL layer%0d_ack: feedback %b en %b expected 1 1", layer, rf_l, en_l);
        else n_pass++;
        if (pix < PIX) exp_err = 1'b1;
        step;
        rf_l = (layer == 2) ? rf2 : rf3;
        n_checks++;
        if ({rf_l, f2_en, f3_en} !== 3'b000) $display("[TB] FAIL layer%0d_post_ack: feedback/en2/en3 %b expected 000", layer, {rf_l, f2_en, f3_en});
        else n_pass++;
    endtask

    task automatic run_sequence(input int n2, input int n3, input bit sim2, input bit sim3, input bit poke3);
        start = 1'b1;
        step;
        start = 1'b0;
        exp_err = 1'b0;
        n_checks++;
        if ({f2_en, f3_en, busy, error} !== 4'b1010) $display("[TB] FAIL start_accept: en2/en3/busy/error %b expected 1010", {f2_en, f3_en, busy, error});
        else n_pass++;
        drive_layer(2, n2, sim2, 1'b0);
        for (int g = 1; g < GAP; g++) begin
            step;
            n_checks++;
            if ({f2_en, f3_en} !== 2'b00) $display("[TB] FAIL gap_idle cycle %0d: en2/en3 %b expected 00", g + 1, {f2_en, f3_en});
            else n_pass++;
        end
        step;
        n_checks++;
        if ({f2_en, f3_en} !== 2'b01) $display("[TB] FAIL fire3_rise: en2/en3 %b expected 01", {f2_en, f3_en});
        else n_pass++;
        drive_layer(3, n3, sim3, poke3);
        n_checks++;
        if (done !== 1'b1 || error !== exp_err) $display("[TB] FAIL seq_done: done %b error %b expected 1 %b", done, error, exp_err);
        else n_pass++;
        step;
        n_checks++;
        if ({done, busy, error} !== {2'b00, exp_err}) $display("[TB] FAIL seq_idle: done/busy/error %b expected 00%b", {done, busy, error}, exp_err);
        else n_pass++;
    endtask

    task automatic test_nominal;
        $display("[TB] nominal run");
        run_sequence(PIX + 1, PIX + 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_early_finish;
        $display("[TB] early finish after 10 samples");
        run_sequence(10, PIX + 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous;
        $display("[TB] sample and finish together at the last pixel");
        run_sequence(PIX, PIX, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored;
        $display("[TB] start re-pulsed during RUN3");
        run_sequence(12, PIX + 1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random_runs;
        for (int r = 0; r < 4; r++) begin
            $display("[TB] random run %0d", r);
            run_sequence($urandom_range(8, PIX + 1), $urandom_range(8, PIX + 1),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_watchdog;
        int en_cnt;
        bit fb_seen;
        $display("[TB] watchdog without finish");
        en_cnt = 0;
        fb_seen = 1'b0;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int c = 0; c < 3 * MAXC; c++) begin
            if (f2_en !== 1'b1) break;
            en_cnt++;
            if (rf2 === 1'b1) fb_seen = 1'b1;
            step;
        end
        n_checks++;
        if (en_cnt != MAXC) $display("[TB] FAIL wd_enable_cycles: got %0d expected %0d", en_cnt, MAXC);
        else n_pass++;
        n_checks++;
        if ({done, error, rf2, f3_en, fb_seen} !== 5'b11000) $display("[TB] FAIL wd_abort: done/error/rf2/en3/fb_seen %b expected 11000", {done, error, rf2, f3_en, fb_seen});
        else n_pass++;
        step;
        n_checks++;
        if ({done, busy, error} !== 3'b001) $display("[TB] FAIL wd_idle: done/busy/error %b expected 001", {done, busy, error});
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        $display("[TB] reset during RUN2");
        start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample = 1'b1;
            step;
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        sample = 1'b0;
        n_checks++;
        if ({f2_en, f3_en, rf2, rf3, wr_en_2, wr_en_3, busy, done, error} !== 9'b0 || wr_addr !== '0)
            $display("[TB] FAIL reset_mid_run: got %b addr %0d expected 0 addr 0", {f2_en, f3_en, rf2, rf3, wr_en_2, wr_en_3, busy, done, error}, wr_addr);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step;
            n_checks++;
            if ({done, busy, f2_en, rf2} !== 4'b0) $display("[TB] FAIL reset_stays_idle: done/busy/en2/rf2 %b expected 0000", {done, busy, f2_en, rf2});
            else n_pass++;
        end
        run_sequence(PIX + 1, PIX + 1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_early_finish;
        test_nominal;
        test_simultaneous;
        test_start_ignored;
        test_random_runs;
        test_watchdog;
        test_reset_mid_run;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
